// File: rtl/light_row_if.sv
// Signal bundle between the game controller and the light_row bar.
// Master drives the control/key levels; slave (the bar) returns LEDs, position, win flags and FSM state.
interface light_row_if #(
    parameter int NUM_LIGHTS = 9
);
    localparam int PW = $clog2(NUM_LIGHTS);

    // No valid/ready here: keys are debounced levels sampled every clk, and
    // the bar derives presses from rising edges; outputs are always valid.
    logic                  clear;
    logic                  hold;
    logic                  l_in;
    logic                  r_in;
    logic [NUM_LIGHTS-1:0] lights;
    logic [PW-1:0]         pos;
    logic                  win_l;
    logic                  win_r;
    logic [1:0]            state;

    modport master (
        output clear, hold, l_in, r_in,
        input  lights, pos, win_l, win_r, state
    );

    modport slave (
        input  clear, hold, l_in, r_in,
        output lights, pos, win_l, win_r, state
    );
endinterface

// File: rtl/light_row.sv
// Tug-of-war light bar: one lit LED moved by rising edges of the L/R keys,
// with freeze, synchronous restart, win detection and optional wrap-around.
module light_row #(
    parameter int NUM_LIGHTS = 9,
    parameter bit WRAP       = 1'b0
) (
    input logic        clk,
    input logic        reset_n,
    light_row_if.slave bus
);
    localparam int PW = $clog2(NUM_LIGHTS);
    localparam logic [PW-1:0] CENTER  = PW'(NUM_LIGHTS / 2);
    localparam logic [PW-1:0] MAX_POS = PW'(NUM_LIGHTS - 1);

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        WON_L = 2'd1,
        WON_R = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pos_q, pos_d;
    logic          l_prev, r_prev;
    logic          l_pr, r_pr;
    logic          mv_l, mv_r;

    assign l_pr = bus.l_in & ~l_prev;
    assign r_pr = bus.r_in & ~r_prev;
    assign mv_l = l_pr & ~r_pr;
    assign mv_r = r_pr & ~l_pr;

    // Edge registers reset to 1 so a key held through reset release is not a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= PLAY;
            pos_q   <= CENTER;
            l_prev  <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            l_prev  <= bus.l_in;
            r_prev  <= bus.r_in;
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        if (bus.clear) begin
            state_d = PLAY;
            pos_d   = CENTER;
        end else if (!bus.hold && state_q == PLAY) begin
            if (mv_r) begin
                if (pos_q != '0)
                    pos_d = pos_q - PW'(1);
                else if (WRAP)
                    pos_d = MAX_POS;
                else
                    state_d = WON_R;
            end else if (mv_l) begin
                if (pos_q != MAX_POS)
                    pos_d = pos_q + PW'(1);
                else if (WRAP)
                    pos_d = '0;
                else
                    state_d = WON_L;
            end
        end
    end

    assign bus.lights = NUM_LIGHTS'(1) << pos_q;
    assign bus.pos    = pos_q;
    assign bus.win_l  = (state_q == WON_L);
    assign bus.win_r  = (state_q == WON_R);
    assign bus.state  = state_q;
endmodule
